// File: rtl/act_feeder.sv
// Activation/weight feeder for an N x N systolic array: loads weights unskewed,
// then streams activation vectors through per-row skew registers, then drains.
module act_feeder #(
    parameter int ARRAY_DIM   = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [COUNT_WIDTH-1:0]          vec_count,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [ARRAY_DIM*DATA_WIDTH-1:0] in_data,
    output logic [ARRAY_DIM*DATA_WIDTH-1:0] row_data,
    output logic                            pe_enable,
    output logic                            pe_load_weight,
    output logic                            busy,
    output logic                            done
);

    localparam int N       = ARRAY_DIM;
    localparam int BEAT_W  = $clog2(N);
    localparam int DRAIN_W = $clog2(2 * N - 1);
    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(N - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2 * N - 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [BEAT_W-1:0]      beat_cnt;
    logic [COUNT_WIDTH-1:0] vec_left;
    logic [DRAIN_W-1:0]     drain_cnt;
    logic                   accept;
    logic                   advance;
    logic                   start_acc;
    logic                   load_acc;
    logic                   shift_en;
    logic                   en_p1;
    logic                   ldw_p1;

    assign in_ready       = (state == LOAD_W) || (state == STREAM);
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign pe_enable      = en_p1;
    assign pe_load_weight = ldw_p1;

    assign accept    = in_valid && in_ready;
    assign advance   = accept || (state == DRAIN);
    assign start_acc = (state == IDLE) && start;
    assign load_acc  = accept && (state == LOAD_W);
    assign shift_en  = advance && ((state == STREAM) || (state == DRAIN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD_W;
            end
            LOAD_W: begin
                if (accept && (beat_cnt == BEAT_LAST)) begin
                    state_nxt = (vec_left == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (accept && (vec_left == COUNT_WIDTH'(1))) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Job counters: vec_left counts down so a full-scale count never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt  <= '0;
            vec_left  <= '0;
            drain_cnt <= '0;
        end else if (start_acc) begin
            beat_cnt  <= '0;
            vec_left  <= vec_count;
            drain_cnt <= '0;
        end else begin
            if (load_acc) beat_cnt <= beat_cnt + BEAT_W'(1);
            if ((state == STREAM) && accept) vec_left <= vec_left - COUNT_WIDTH'(1);
            if (state == DRAIN) drain_cnt <= drain_cnt + DRAIN_W'(1);
        end
    end

    // Stage p1: array control strobes, one cycle behind the advance decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_p1  <= 1'b0;
            ldw_p1 <= 1'b0;
        end else begin
            en_p1  <= advance;
            ldw_p1 <= load_acc;
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        logic [DATA_WIDTH-1:0] feed;
        logic [DATA_WIDTH-1:0] row_p1;

        assign feed = (state == STREAM) ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign row_data[r*DATA_WIDTH +: DATA_WIDTH] = row_p1;

        if (r == 0) begin : g_noskew
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    row_p1 <= '0;
                end else if (load_acc) begin
                    row_p1 <= in_data[r*DATA_WIDTH +: DATA_WIDTH];
                end else if (shift_en) begin
                    row_p1 <= feed;
                end
            end
        end else begin : g_skew
            // Stage p0: r skew stages ahead of the output register for row r.
            logic [DATA_WIDTH-1:0] skew_p0 [r];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int j = 0; j < r; j++) skew_p0[j] <= '0;
                    row_p1 <= '0;
                end else if (start_acc) begin
                    for (int j = 0; j < r; j++) skew_p0[j] <= '0;
                end else if (load_acc) begin
                    row_p1 <= in_data[r*DATA_WIDTH +: DATA_WIDTH];
                end else if (shift_en) begin
                    skew_p0[0] <= feed;
                    for (int j = 1; j < r; j++) skew_p0[j] <= skew_p0[j-1];
                    row_p1 <= skew_p0[r-1];
                end
            end
        end
    end

endmodule
